branch_ctrl: RTL and testbench

- Sequencing controller for the ID-stage branch resolution unit.
- Holds a branch in ID while its operands are still being produced, then samples the branch decision (zero) and target when the operands are ready.
- On a taken branch, issues a one-cycle PC redirect and an IF/ID flush.
- Keeps saturating branch/taken statistics; an external pipeline flush (exception) has top priority.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/sat_counter.sv | 32 +++
 rtl/branch_ctrl.sv | 133 +++++++++++++
 tb/tb_branch_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg : ALUOp branch encodings, branch controller states, helpers
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam logic [3:0] BR_BEQ = 4'b0100;
  localparam logic [3:0] BR_BNE = 4'b0101;
  localparam logic [3:0] BR_BGT = 4'b0110;
  localparam logic [3:0] BR_BLT = 4'b0111;
  localparam logic [3:0] BR_BGE = 4'b1000;
  localparam logic [3:0] BR_BLE = 4'b1001;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    REDIRECT = 2'd2
  } br_state_e;

  function automatic logic is_branch_op(input logic [3:0] op);
    return (op >= BR_BEQ) && (op <= BR_BLE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter : W-bit up-counter that sticks at all-ones
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl : ID-stage branch sequencing (operand wait, redirect, stats)
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 7,
  parameter int WAIT_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic [3:0]       alu_op,
  input  logic             opnd_busy,
  input  logic             zero,
  input  logic [31:0]      br_target,
  input  logic             pipe_flush,
  output logic             branch_flag,
  output logic             stall_id,
  output logic             pc_sel,
  output logic [31:0]      pc_target,
  output logic             flush_if_id,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count,
  output logic             wait_timeout
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  br_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              redir_q, redir_d;
  logic [31:0]       target_q, target_d;
  logic              timeout_q, timeout_d;
  logic              is_br, resolve, taken;

  assign is_br = br_valid && is_branch_op(alu_op);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    resolve    = 1'b0;
    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (is_br && opnd_busy) begin
          state_d    = WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else if (is_br) begin
          resolve = 1'b1;
        end
      end
      WAIT: begin
        if (!is_br) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (opnd_busy) begin
          if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
          resolve    = 1'b1;
          wait_cnt_d = '0;
        end
      end
      REDIRECT: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase

    if (resolve) state_d = zero ? REDIRECT : IDLE;

    // An exception flush overrides everything, including a same-cycle resolve.
    if (pipe_flush) begin
      state_d    = IDLE;
      wait_cnt_d = '0;
      resolve    = 1'b0;
    end
  end

  assign taken     = resolve && zero;
  assign redir_d   = taken;
  assign target_d  = taken ? br_target : target_q;
  assign timeout_d = timeout_q | ((state_d == WAIT) && (wait_cnt_d == WAIT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      redir_q    <= 1'b0;
      target_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      redir_q    <= redir_d;
      target_q   <= target_d;
      timeout_q  <= timeout_d;
    end
  end

  assign branch_flag  = is_br && (state_q != REDIRECT);
  assign stall_id     = is_br && opnd_busy && !pipe_flush &&
                        ((state_q == IDLE) || (state_q == WAIT));
  assign pc_sel       = redir_q;
  assign flush_if_id  = redir_q;
  assign pc_target    = target_q;
  assign wait_timeout = timeout_q;

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (resolve),
    .value_o (br_count)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (taken),
    .value_o (taken_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_ctrl : directed table, corner sequences and random model check
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_branch_ctrl;
  import mips_pkg::*;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 7;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             br_valid, opnd_busy, zero, pipe_flush;
  logic [3:0]       alu_op;
  logic [31:0]      br_target;
  logic             branch_flag, stall_id, pc_sel, flush_if_id, wait_timeout;
  logic [31:0]      pc_target;
  logic [CNT_W-1:0] br_count, taken_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT), .WAIT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .br_valid     (br_valid),
    .alu_op       (alu_op),
    .opnd_busy    (opnd_busy),
    .zero         (zero),
    .br_target    (br_target),
    .pipe_flush   (pipe_flush),
    .branch_flag  (branch_flag),
    .stall_id     (stall_id),
    .pc_sel       (pc_sel),
    .pc_target    (pc_target),
    .flush_if_id  (flush_if_id),
    .br_count     (br_count),
    .taken_count  (taken_count),
    .wait_timeout (wait_timeout)
  );

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic        b, z;
    logic [31:0] t;
    logic        f;
    logic        e_bf, e_st, e_pc;
    int          e_brc, e_tkc;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic v, input logic [3:0] op, input logic b,
                              input logic z, input logic [31:0] t, input logic f,
                              input logic e_bf, input logic e_st, input logic e_pc,
                              input int e_brc, input int e_tkc, input logic [31:0] e_tgt);
    vec_t r;
    r.v = v; r.op = op; r.b = b; r.z = z; r.t = t; r.f = f;
    r.e_bf = e_bf; r.e_st = e_st; r.e_pc = e_pc;
    r.e_brc = e_brc; r.e_tkc = e_tkc; r.e_tgt = e_tgt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic b,
                       input logic z, input logic [31:0] t, input logic f);
    br_valid = v; alu_op = op; opnd_busy = b; zero = z; br_target = t; pipe_flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: "redirect owed next cycle" flag plus a count of cycles waited.
  bit          m_redir;
  int          m_waited;
  int          m_brc, m_tkc;
  bit          m_to;
  logic [31:0] m_tgt;

  initial begin
    rst_n = 1'b0;
    drive(0, 4'd0, 0, 0, 32'd0, 0);
    #3;
    chk("rst_pc_sel", pc_sel, 0);
    chk("rst_flush", flush_if_id, 0);
    chk("rst_target", pc_target, 0);
    chk("rst_brc", br_count, 0);
    chk("rst_tkc", taken_count, 0);
    chk("rst_timeout", wait_timeout, 0);
    #9 rst_n = 1'b1;
    tick();

    tbl[0]  = mk(1, BR_BEQ, 0, 1, 32'h0040_0040, 0, 1, 0, 1, 1, 1, 32'h0040_0040);
    tbl[1]  = mk(1, BR_BEQ, 0, 1, 32'hBAD0_BAD0, 0, 0, 0, 0, 1, 1, 32'h0040_0040);
    tbl[2]  = mk(0, 4'd0,   0, 0, 32'h0,         0, 0, 0, 0, 1, 1, 32'h0040_0040);
    tbl[3]  = mk(1, BR_BNE, 1, 1, 32'hBAD,       0, 1, 1, 0, 1, 1, 32'h0040_0040);
    tbl[4]  = mk(1, BR_BNE, 1, 1, 32'hBAD,       0, 1, 1, 0, 1, 1, 32'h0040_0040);
    tbl[5]  = mk(1, BR_BNE, 1, 1, 32'hBAD,       0, 1, 1, 0, 1, 1, 32'h0040_0040);
    tbl[6]  = mk(1, BR_BNE, 0, 0, 32'hBAD,       0, 1, 0, 0, 2, 1, 32'h0040_0040);
    tbl[7]  = mk(1, 4'b0010, 1, 1, 32'hBAD,      0, 0, 0, 0, 2, 1, 32'h0040_0040);
    tbl[8]  = mk(1, BR_BGT, 0, 1, 32'h0000_1234, 0, 1, 0, 1, 3, 2, 32'h0000_1234);
    tbl[9]  = mk(0, 4'd0,   0, 0, 32'h0,         1, 0, 0, 0, 3, 2, 32'h0000_1234);
    tbl[10] = mk(1, BR_BLT, 1, 0, 32'h0,         0, 1, 1, 0, 3, 2, 32'h0000_1234);
    tbl[11] = mk(1, BR_BLT, 1, 0, 32'h0,         1, 1, 0, 0, 3, 2, 32'h0000_1234);
    tbl[12] = mk(1, BR_BLT, 0, 1, 32'hBAD,       1, 1, 0, 0, 3, 2, 32'h0000_1234);
    tbl[13] = mk(1, BR_BGE, 0, 0, 32'hBAD,       0, 1, 0, 0, 4, 2, 32'h0000_1234);
    tbl[14] = mk(1, BR_BLE, 0, 1, 32'hDEAD_0000, 0, 1, 0, 1, 5, 3, 32'hDEAD_0000);
    tbl[15] = mk(0, 4'd0,   0, 0, 32'h0,         0, 0, 0, 0, 5, 3, 32'hDEAD_0000);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].b, tbl[i].z, tbl[i].t, tbl[i].f);
      #1;
      chk($sformatf("tbl%0d_branch_flag", i), branch_flag, tbl[i].e_bf);
      chk($sformatf("tbl%0d_stall", i), stall_id, tbl[i].e_st);
      tick();
      chk($sformatf("tbl%0d_pc_sel", i), pc_sel, tbl[i].e_pc);
      chk($sformatf("tbl%0d_flush", i), flush_if_id, tbl[i].e_pc);
      chk($sformatf("tbl%0d_brc", i), br_count, tbl[i].e_brc);
      chk($sformatf("tbl%0d_tkc", i), taken_count, tbl[i].e_tkc);
      chk($sformatf("tbl%0d_target", i), pc_target, tbl[i].e_tgt);
      chk($sformatf("tbl%0d_timeout", i), wait_timeout, 0);
    end

    // Operand wait of 9 cycles: timeout becomes visible after the 7th stall cycle.
    for (int i = 0; i < 9; i++) begin
      drive(1, BR_BLT, 1, 0, 32'h0, 0);
      #1;
      chk($sformatf("to_stall%0d", i), stall_id, 1);
      tick();
      chk($sformatf("to_flag%0d", i), wait_timeout, (i >= 6) ? 1 : 0);
    end
    drive(1, BR_BLT, 0, 1, 32'h0040_0080, 0);
    #1;
    chk("to_resolve_stall", stall_id, 0);
    tick();
    chk("to_redirect", pc_sel, 1);
    chk("to_target", pc_target, 32'h0040_0080);
    chk("to_sticky", wait_timeout, 1);
    chk("to_brc", br_count, 6);
    chk("to_tkc", taken_count, 4);
    drive(0, 4'd0, 0, 0, 32'h0, 0);
    tick();
    chk("to_redirect_end", pc_sel, 0);
    chk("to_sticky2", wait_timeout, 1);

    for (int i = 0; i < 20; i++) begin
      drive(1, BR_BEQ, 0, 1, 32'h100 + i, 0);
      tick();
      drive(0, 4'd0, 0, 0, 32'h0, 0);
      tick();
    end
    chk("sat_brc", br_count, CNT_MAX);
    chk("sat_tkc", taken_count, CNT_MAX);
    chk("sat_target", pc_target, 32'h100 + 19);

    // Asynchronous reset pulse while waiting on operands.
    drive(1, BR_BNE, 1, 0, 32'h0, 0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc_sel", pc_sel, 0);
    chk("arst_flush", flush_if_id, 0);
    chk("arst_target", pc_target, 0);
    chk("arst_brc", br_count, 0);
    chk("arst_tkc", taken_count, 0);
    chk("arst_timeout", wait_timeout, 0);
    drive(0, 4'd0, 0, 0, 32'h0, 0);
    #1 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1, BR_BNE, 1, 0, 32'h0, 0);
      tick();
      chk($sformatf("arst_wait%0d", i), wait_timeout, (i == 6) ? 1 : 0);
    end
    drive(1, BR_BNE, 0, 0, 32'h0, 0);
    tick();
    chk("arst_resolve_brc", br_count, 1);
    chk("arst_resolve_pc", pc_sel, 0);

    // Randomized run against the reference model.
    drive(0, 4'd0, 0, 0, 32'h0, 0);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    m_redir = 0; m_waited = 0; m_brc = 0; m_tkc = 0; m_to = 0; m_tgt = '0;
    for (int n = 0; n < 3000; n++) begin
      logic        v, b, z, f, isbr;
      logic [3:0]  op;
      logic [31:0] t;
      v  = ($urandom_range(0, 9) < 7);
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(4, 9));
      b  = ($urandom_range(0, 9) < 4);
      z  = 1'($urandom_range(0, 1));
      t  = $urandom;
      f  = ($urandom_range(0, 19) == 0);
      drive(v, op, b, z, t, f);
      isbr = v && (op >= 4'd4) && (op <= 4'd9);
      #1;
      chk("rnd_branch_flag", branch_flag, isbr && !m_redir);
      chk("rnd_stall", stall_id, isbr && b && !m_redir && !f);
      if (f || m_redir) begin
        m_redir  = 0;
        m_waited = 0;
      end else if (isbr && b) begin
        m_waited = (m_waited >= MAX_WAIT) ? MAX_WAIT : m_waited + 1;
        if (m_waited == MAX_WAIT) m_to = 1;
      end else if (isbr) begin
        m_waited = 0;
        if (m_brc < CNT_MAX) m_brc++;
        if (z) begin
          if (m_tkc < CNT_MAX) m_tkc++;
          m_tgt   = t;
          m_redir = 1;
        end
      end else begin
        m_waited = 0;
      end
      tick();
      chk("rnd_pc_sel", pc_sel, m_redir);
      chk("rnd_flush", flush_if_id, m_redir);
      chk("rnd_brc", br_count, m_brc);
      chk("rnd_tkc", taken_count, m_tkc);
      chk("rnd_timeout", wait_timeout, m_to);
      chk("rnd_target", pc_target, m_tgt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
